// File: rtl/pdm_to_pcm_decimator.sv
// -----------------------------------------------------------------------------
// pdm_to_pcm_decimator
//
// Front end of the audio chain. Generates the PDM microphone clock, samples the
// 1-bit PDM stream and decimates it with a 4th-order CIC (Hogenauer) filter.
// It emits 16-bit offset-binary PCM words with a one-cycle valid strobe.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous, active-low reset
//   en         in   run enable; low freezes the block
//   pdm_data   in   PDM bit from the microphone (asynchronous to clk)
//   pdm_clk    out  clock driven to the microphone (registered)
//   pcm        out  16-bit decimated sample, offset binary (midpoint 16'h8000)
//   pcm_valid  out  one-cycle strobe when pcm updates
//   clip       out  sticky flag: an emitted word was saturated
// -----------------------------------------------------------------------------
module pdm_to_pcm_decimator #(
    parameter int CLK_DIV = 50,
    parameter int DECIM   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pdm_data,
    output logic        pdm_clk,
    output logic [15:0] pcm,
    output logic        pcm_valid,
    output logic        clip
);

    localparam int LOG2_DECIM = $clog2(DECIM);
    // Internal width covers the full CIC gain DECIM^4 plus sign and +/-1 input.
    localparam int W          = 2 + 4 * LOG2_DECIM;
    // Drops the CIC gain down to a 16-bit nominal range of [-32768, +32768].
    localparam int SHIFT      = 4 * LOG2_DECIM - 15;
    localparam int HALF       = CLK_DIV / 2;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int DEC_W      = LOG2_DECIM;

    localparam logic signed [W-1:0] PCM_MAX = W'(32'sd32767);
    localparam logic signed [W-1:0] PCM_MIN = W'(-32'sd32768);

    // Saturate a scaled comb result to 16 bits. Returns {clip, offset_binary}.
    function automatic logic [16:0] sat_to_pcm(input logic signed [W-1:0] v);
        logic [16:0] r;
        if (v > PCM_MAX) begin
            r = {1'b1, 16'h7FFF};
        end else if (v < PCM_MIN) begin
            r = {1'b1, 16'h8000};
        end else begin
            r = {1'b0, v[15:0]};
        end
        sat_to_pcm = {r[16], ~r[15], r[14:0]};
    endfunction

    // ---------------------------------------------------------------- signals
    logic [DIV_W-1:0]     div_cnt_r;
    logic [DIV_W-1:0]     div_cnt_nxt_s;
    logic                 pdm_clk_r;
    logic                 strobe_s;

    logic                 sync1_r;
    logic                 sync2_r;
    logic signed [W-1:0]  x_s;

    logic signed [W-1:0]  int0_r;
    logic signed [W-1:0]  int1_r;
    logic signed [W-1:0]  int2_r;
    logic signed [W-1:0]  int3_r;

    logic [DEC_W-1:0]     dec_cnt_r;
    logic                 dec_last_s;
    logic                 dec_pend_r;
    logic                 out_pend_r;

    logic signed [W-1:0]  dly0_r;
    logic signed [W-1:0]  dly1_r;
    logic signed [W-1:0]  dly2_r;
    logic signed [W-1:0]  dly3_r;
    logic signed [W-1:0]  c0_s;
    logic signed [W-1:0]  c1_s;
    logic signed [W-1:0]  c2_s;
    logic signed [W-1:0]  c3_s;
    logic signed [W-1:0]  comb_out_r;
    logic signed [W-1:0]  shifted_s;
    logic [16:0]          sat_s;

    logic [2:0]           warm_cnt_r;
    logic [15:0]          pcm_r;
    logic                 pcm_valid_r;
    logic                 clip_r;

    // ---------------------------------------------------------- clock divider
    // Next divider count: held at zero while disabled, wraps at CLK_DIV-1.
    always_comb begin
        div_cnt_nxt_s = {DIV_W{1'b0}};
        if (!en) begin
            div_cnt_nxt_s = {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_W'(CLK_DIV - 1)) begin
            div_cnt_nxt_s = {DIV_W{1'b0}};
        end else begin
            div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
        end
    end

    // Divider counter and registered PDM clock. pdm_clk is derived from the
    // next count so that it lines up with div_cnt_r in the same cycle; the en
    // gate forces it low while the divider is parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            pdm_clk_r <= 1'b0;
        end else begin
            div_cnt_r <= div_cnt_nxt_s;
            pdm_clk_r <= en && (div_cnt_nxt_s < DIV_W'(HALF));
        end
    end

    // Sample on the last high cycle of pdm_clk, when the mic data is settled.
    assign strobe_s   = en && (div_cnt_r == DIV_W'(HALF - 1));
    assign dec_last_s = strobe_s && (dec_cnt_r == DEC_W'(DECIM - 1));

    // ---------------------------------------------------------- input capture
    // Two-flop synchronizer for the asynchronous PDM bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pdm_data;
            sync2_r <= sync1_r;
        end
    end

    // Bit 1 maps to +1, bit 0 maps to -1.
    assign x_s = sync2_r ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

    // ------------------------------------------------------------ integrators
    // Four pipelined integrators; each stage adds the previous stage's old
    // value. Wrap-around modulo 2^W is harmless because the combs undo it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int0_r <= {W{1'b0}};
            int1_r <= {W{1'b0}};
            int2_r <= {W{1'b0}};
            int3_r <= {W{1'b0}};
        end else if (strobe_s) begin
            int0_r <= int0_r + x_s;
            int1_r <= int1_r + int0_r;
            int2_r <= int2_r + int1_r;
            int3_r <= int3_r + int2_r;
        end
    end

    // Decimation counter and the two-stage output pipeline flags. The pipeline
    // flags are not gated by en so an in-flight word always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_r  <= {DEC_W{1'b0}};
            dec_pend_r <= 1'b0;
            out_pend_r <= 1'b0;
        end else begin
            if (strobe_s) begin
                dec_cnt_r <= dec_cnt_r + DEC_W'(1);
            end
            dec_pend_r <= dec_last_s;
            out_pend_r <= dec_pend_r;
        end
    end

    // ------------------------------------------------------------------ combs
    // Four cascaded differentiators with differential delay 1.
    always_comb begin
        c0_s = int3_r - dly0_r;
        c1_s = c0_s - dly1_r;
        c2_s = c1_s - dly2_r;
        c3_s = c2_s - dly3_r;
    end

    // Comb delay lines and result register, updated once per decimated word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly0_r     <= {W{1'b0}};
            dly1_r     <= {W{1'b0}};
            dly2_r     <= {W{1'b0}};
            dly3_r     <= {W{1'b0}};
            comb_out_r <= {W{1'b0}};
        end else if (dec_pend_r) begin
            dly0_r     <= int3_r;
            dly1_r     <= c0_s;
            dly2_r     <= c1_s;
            dly3_r     <= c2_s;
            comb_out_r <= c3_s;
        end
    end

    // Scale and saturate the comb result.
    always_comb begin
        shifted_s = comb_out_r >>> SHIFT;
        sat_s     = sat_to_pcm(shifted_s);
    end

    // ---------------------------------------------------------------- output
    // Output register with warm-up suppression: the first four words come out
    // of comb delay lines that are still filling, so they are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_r  <= 3'd0;
            pcm_r       <= 16'h8000;
            pcm_valid_r <= 1'b0;
            clip_r      <= 1'b0;
        end else if (out_pend_r) begin
            if (warm_cnt_r == 3'd4) begin
                pcm_r       <= sat_s[15:0];
                pcm_valid_r <= 1'b1;
                if (sat_s[16]) begin
                    clip_r <= 1'b1;
                end
            end else begin
                warm_cnt_r  <= warm_cnt_r + 3'd1;
                pcm_valid_r <= 1'b0;
            end
        end else begin
            pcm_valid_r <= 1'b0;
        end
    end

    assign pdm_clk   = pdm_clk_r;
    assign pcm       = pcm_r;
    assign pcm_valid = pcm_valid_r;
    assign clip      = clip_r;

endmodule

// File: tb/tb_pdm_to_pcm_decimator.sv
// -----------------------------------------------------------------------------
// tb_pdm_to_pcm_decimator
//
// Directed self-checking bench. A helper process plays a repeating 4-bit
// pattern onto pdm_data, advancing one bit per falling edge of pdm_clk; the
// main initial block walks through the scenarios and compares outputs against
// hand-derived values. DECIM is reduced to 32 to keep run time short; the
// expected PCM codes do not depend on DECIM.
// -----------------------------------------------------------------------------
module tb_pdm_to_pcm_decimator;

    localparam int CLK_DIV = 50;
    localparam int DECIM   = 32;
    localparam int PERIOD  = CLK_DIV * DECIM;
    // Strobe k lands on edge CLK_DIV/2 + CLK_DIV*k after release; the 5th word
    // ends at strobe 5*DECIM-1 and shows on pcm_valid two edges later.
    localparam int FIRST_VALID = CLK_DIV / 2 + CLK_DIV * (5 * DECIM - 1) + 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        pdm_data;
    logic        pdm_clk;
    logic [15:0] pcm;
    logic        pcm_valid;
    logic        clip;

    logic [3:0]  pat;
    int          errors;
    int          checks;
    int          cyc;

    pdm_to_pcm_decimator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pdm_data  (pdm_data),
        .pdm_clk   (pdm_clk),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .clip      (clip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pattern player: next bit on each falling edge of pdm_clk.
    initial begin
        logic [1:0] idx;
        idx      = 2'd0;
        pdm_data = 1'b0;
        forever begin
            @(negedge pdm_clk);
            pdm_data = pat[idx];
            idx      = idx + 2'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget, output int n);
        bit found;
        n     = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (pcm_valid === 1'b1) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_pdm(input logic lvl, output int n);
        bit found;
        n     = 0;
        found = 1'b0;
        while (!found && n < 4 * CLK_DIV) begin
            tick();
            n++;
            if (pdm_clk === lvl) found = 1'b1;
        end
        chk("pdm_clk_wait", 32'(found), 32'd1);
    endtask

    task automatic settle(input string tag);
        int n;
        for (int i = 0; i < 5; i++) begin
            wait_valid(tag, PERIOD + 100, n);
        end
    endtask

    initial begin
        int n;
        int n_hi;
        int n_lo;
        int t_valid;
        int valids;
        int highs;

        errors = 0;
        checks = 0;
        cyc    = 0;
        pat    = 4'b0101;
        en     = 1'b1;
        rst_n  = 1'b0;

        // Reset state.
        #23;
        chk("rst_pcm",       32'(pcm),       32'h8000);
        chk("rst_pcm_valid", 32'(pcm_valid), 32'd0);
        chk("rst_pdm_clk",   32'(pdm_clk),   32'd0);
        chk("rst_clip",      32'(clip),      32'd0);
        #14;
        rst_n = 1'b1;

        // Warm-up: first word only after five frames.
        wait_valid("first_valid_timeout", FIRST_VALID + 100, n);
        chk("first_valid_latency", 32'(n), 32'(FIRST_VALID));
        chk("alt_pcm_first", 32'(pcm), 32'h8000);
        chk("alt_clip",      32'(clip), 32'd0);
        tick();
        chk("valid_width", 32'(pcm_valid), 32'd0);
        wait_valid("period_timeout", PERIOD + 100, n);
        chk("valid_period", 32'(n + 1), 32'(PERIOD));
        chk("alt_pcm_second", 32'(pcm), 32'h8000);

        // PDM clock shape.
        wait_pdm(1'b0, n);
        wait_pdm(1'b1, n);
        wait_pdm(1'b0, n_hi);
        wait_pdm(1'b1, n_lo);
        chk("pdm_clk_high",   32'(n_hi),        32'(CLK_DIV / 2));
        chk("pdm_clk_period", 32'(n_hi + n_lo), 32'(CLK_DIV));

        // en low for 1000 cycles mid-frame, dropped during the low phase.
        wait_valid("pause_sync_timeout", PERIOD + 100, n);
        t_valid = cyc;
        repeat (300) tick();
        wait_pdm(1'b1, n);
        wait_pdm(1'b0, n);
        tick();
        en     = 1'b0;
        valids = 0;
        highs  = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (pcm_valid === 1'b1) valids++;
            if (pdm_clk !== 1'b0) highs++;
        end
        chk("pause_no_valid",   32'(valids), 32'd0);
        chk("pause_pdm_clk_lo", 32'(highs),  32'd0);
        chk("pause_pcm_held",   32'(pcm),    32'h8000);
        en = 1'b1;
        wait_valid("resume_timeout", PERIOD + 200, n);
        chk_range("resume_interval", cyc - t_valid, PERIOD + 1000 - 50, PERIOD + 1000 + 50);
        chk("resume_pcm", 32'(pcm), 32'h8000);

        // en drops right after the decimating strobe: word still completes.
        repeat (PERIOD - 2) tick();
        en = 1'b0;
        wait_valid("pipe_drop_timeout", 10, n);
        chk("pipe_drop_latency", 32'(n), 32'd2);
        chk("pipe_drop_pcm", 32'(pcm), 32'h8000);
        repeat (20) tick();
        en = 1'b1;

        // Constant 0 -> full negative scale.
        pat = 4'b0000;
        settle("zero_timeout");
        chk("zero_pcm",  32'(pcm),  32'h0000);
        chk("zero_clip", 32'(clip), 32'd0);

        // 1,0,0,0 -> -16384.
        pat = 4'b0001;
        settle("q1_timeout");
        chk("q1_pcm", 32'(pcm), 32'h4000);

        // 1,1,1,0 -> +16384.
        pat = 4'b0111;
        settle("q3_timeout");
        chk("q3_pcm",  32'(pcm),  32'hC000);
        chk("q3_clip", 32'(clip), 32'd0);

        // Constant 1 -> +32768 saturates to 32767.
        pat = 4'b1111;
        settle("one_timeout");
        chk("one_pcm",  32'(pcm),  32'hFFFF);
        chk("one_clip", 32'(clip), 32'd1);

        // en dropped while pdm_clk is high: low on the next cycle.
        wait_pdm(1'b1, n);
        en = 1'b0;
        tick();
        chk("en_low_pdm_clk", 32'(pdm_clk), 32'd0);
        chk("clip_sticky",    32'(clip),    32'd1);
        en = 1'b1;

        // Asynchronous reset mid-frame.
        pat = 4'b0101;
        repeat (777) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pcm",       32'(pcm),       32'h8000);
        chk("mid_rst_pcm_valid", 32'(pcm_valid), 32'd0);
        chk("mid_rst_pdm_clk",   32'(pdm_clk),   32'd0);
        chk("mid_rst_clip",      32'(clip),      32'd0);
        #20;
        rst_n = 1'b1;
        wait_valid("mid_rst_valid_timeout", FIRST_VALID + 100, n);
        chk("mid_rst_latency", 32'(n), 32'(FIRST_VALID));
        chk("mid_rst_pcm_out", 32'(pcm), 32'h8000);
        chk("mid_rst_clip_out", 32'(clip), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
